// File: rtl/tt_um_emern_scene_regfile_pkg.sv
// Shared constants, opcodes and FSM encoding for the scene register file.
package tt_um_emern_scene_regfile_pkg;

   localparam int unsigned N_POLY   = 6;
   localparam int unsigned WPX      = 10;
   localparam int unsigned WPY      = 9;
   localparam int unsigned WCOLOR   = 6;
   localparam int unsigned LOAD_LEN = 13;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned IDX_W    = 3;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_SET_BG = 3'd2;
   localparam logic [2:0] OP_SET_EN = 3'd3;
   localparam logic [2:0] OP_COMMIT = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD_PL   = 3'd1,
      ST_BG_PL     = 3'd2,
      ST_EN_PL     = 3'd3,
      ST_WAIT_SWAP = 3'd4
   } state_t;

   // True when a header slot index addresses an existing polygon slot.
   function automatic logic slot_ok(input logic [IDX_W-1:0] idx);
      return 32'(idx) < N_POLY;
   endfunction

endpackage

// File: rtl/tt_um_emern_poly_slot.sv
// One polygon slot: shadow copy written field by field, active copy updated on swap.
module tt_um_emern_poly_slot
   import tt_um_emern_scene_regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CNT_W-1:0]  field_sel,
   input  logic [7:0]        wr_data,
   input  logic              swap,
   output logic [WCOLOR-1:0] color,
   output logic [WPX-1:0]    v0_x,
   output logic [WPY-1:0]    v0_y,
   output logic [WPX-1:0]    v1_x,
   output logic [WPY-1:0]    v1_y,
   output logic [WPX-1:0]    v2_x,
   output logic [WPY-1:0]    v2_y
);

   logic [WCOLOR-1:0] sh_color;
   logic [WPX-1:0]    sh_x [3];
   logic [WPY-1:0]    sh_y [3];
   logic [WCOLOR-1:0] act_color;
   logic [WPX-1:0]    act_x [3];
   logic [WPY-1:0]    act_y [3];

   // Field 1..12 maps to vertex (f-1)/4, sub-field x_lo, x_hi, y_lo, y_hi.
   logic [CNT_W-1:0] f_m1;
   logic [1:0]       vtx;
   logic [1:0]       sub;

   assign f_m1 = field_sel - 4'd1;
   assign vtx  = f_m1[3:2];
   assign sub  = f_m1[1:0];

   // Shadow writes from the payload stream and shadow-to-active copy on swap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_color  <= '0;
         act_color <= '0;
         for (int k = 0; k < 3; k++) begin
            sh_x[k]  <= '0;
            sh_y[k]  <= '0;
            act_x[k] <= '0;
            act_y[k] <= '0;
         end
      end else begin
         if (wr_en) begin
            if (field_sel == 4'd0) begin
               sh_color <= wr_data[WCOLOR-1:0];
            end else if (vtx != 2'd3) begin
               case (sub)
                  2'd0:    sh_x[vtx][7:0]     <= wr_data;
                  2'd1:    sh_x[vtx][WPX-1:8] <= wr_data[WPX-9:0];
                  2'd2:    sh_y[vtx][7:0]     <= wr_data;
                  default: sh_y[vtx][WPY-1:8] <= wr_data[WPY-9:0];
               endcase
            end
         end
         if (swap) begin
            act_color <= sh_color;
            for (int k = 0; k < 3; k++) begin
               act_x[k] <= sh_x[k];
               act_y[k] <= sh_y[k];
            end
         end
      end
   end

   assign color = act_color;
   assign v0_x  = act_x[0];
   assign v0_y  = act_y[0];
   assign v1_x  = act_x[1];
   assign v1_y  = act_y[1];
   assign v2_x  = act_x[2];
   assign v2_y  = act_y[2];

endmodule

// File: rtl/tt_um_emern_scene_regfile.sv
// Scene register file: byte command deserialiser with double-buffered polygon state.
module tt_um_emern_scene_regfile
   import tt_um_emern_scene_regfile_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     frame_start,
   output logic [N_POLY-1:0]        cmp_en,
   output logic [WCOLOR-1:0]        background_color,
   output logic [WCOLOR*N_POLY-1:0] poly_color,
   output logic [WPX*N_POLY-1:0]    v0_x,
   output logic [WPX*N_POLY-1:0]    v1_x,
   output logic [WPX*N_POLY-1:0]    v2_x,
   output logic [WPY*N_POLY-1:0]    v0_y,
   output logic [WPY*N_POLY-1:0]    v1_y,
   output logic [WPY*N_POLY-1:0]    v2_y,
   output logic                     commit_pending,
   output logic                     cmd_err
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic              bad_idx;
   logic [WCOLOR-1:0] sh_bg;
   logic [N_POLY-1:0] sh_en;

   logic              accept;
   logic              swap;
   logic [2:0]        hdr_op;
   logic [IDX_W-1:0]  hdr_idx;

   assign accept  = in_valid & in_ready;
   assign swap    = (state == ST_WAIT_SWAP) & frame_start;
   assign hdr_op  = in_data[7:5];
   assign hdr_idx = in_data[2:0];

   // Command FSM, payload counter, background/enable shadow and active registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         idx              <= '0;
         bad_idx          <= 1'b0;
         sh_bg            <= '0;
         sh_en            <= '0;
         background_color <= '0;
         cmp_en           <= '0;
         in_ready         <= 1'b1;
         commit_pending   <= 1'b0;
         cmd_err          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (hdr_op)
                     OP_NOP: ;
                     OP_LOAD: begin
                        state   <= ST_LOAD_PL;
                        cnt     <= '0;
                        idx     <= hdr_idx;
                        bad_idx <= ~slot_ok(hdr_idx);
                        if (!slot_ok(hdr_idx)) cmd_err <= 1'b1;
                     end
                     OP_SET_BG: state <= ST_BG_PL;
                     OP_SET_EN: state <= ST_EN_PL;
                     OP_COMMIT: begin
                        state          <= ST_WAIT_SWAP;
                        in_ready       <= 1'b0;
                        commit_pending <= 1'b1;
                     end
                     default: cmd_err <= 1'b1;
                  endcase
               end
            end
            ST_LOAD_PL: begin
               if (accept) begin
                  if (cnt == CNT_W'(LOAD_LEN - 1)) begin
                     state <= ST_IDLE;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
            end
            ST_BG_PL: begin
               if (accept) begin
                  sh_bg <= in_data[WCOLOR-1:0];
                  state <= ST_IDLE;
               end
            end
            ST_EN_PL: begin
               if (accept) begin
                  sh_en <= in_data[N_POLY-1:0];
                  state <= ST_IDLE;
               end
            end
            ST_WAIT_SWAP: begin
               if (frame_start) begin
                  background_color <= sh_bg;
                  cmp_en           <= sh_en;
                  commit_pending   <= 1'b0;
                  in_ready         <= 1'b1;
                  state            <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

   // Polygon slots; each is written only when its index owns the current LOAD.
   for (genvar g = 0; g < int'(N_POLY); g++) begin : g_slot
      logic wr_en;
      assign wr_en = (state == ST_LOAD_PL) & accept & ~bad_idx & (idx == IDX_W'(g));

      tt_um_emern_poly_slot u_slot (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_en),
         .field_sel (cnt),
         .wr_data   (in_data),
         .swap      (swap),
         .color     (poly_color[g*WCOLOR +: WCOLOR]),
         .v0_x      (v0_x[g*WPX +: WPX]),
         .v0_y      (v0_y[g*WPY +: WPY]),
         .v1_x      (v1_x[g*WPX +: WPX]),
         .v1_y      (v1_y[g*WPY +: WPY]),
         .v2_x      (v2_x[g*WPX +: WPX]),
         .v2_y      (v2_y[g*WPY +: WPY])
      );
   end

endmodule

// File: tb/tb_tt_um_emern_scene_regfile.sv
// Directed bench for the scene register file with a small shadow/active model.
module tb_tt_um_emern_scene_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        frame_start;
   logic [5:0]  cmp_en;
   logic [5:0]  background_color;
   logic [35:0] poly_color;
   logic [59:0] v0_x, v1_x, v2_x;
   logic [53:0] v0_y, v1_y, v2_y;
   logic        commit_pending;
   logic        cmd_err;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: shadow and active images.
   logic [5:0] sh_c [6];
   logic [9:0] sh_x [6][3];
   logic [8:0] sh_y [6][3];
   logic [5:0] ac_c [6];
   logic [9:0] ac_x [6][3];
   logic [8:0] ac_y [6][3];
   logic [5:0] sh_bg, ac_bg, sh_en, ac_en;
   logic [7:0] pl [13];

   always #5 clk = ~clk;

   tt_um_emern_scene_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .frame_start      (frame_start),
      .cmp_en           (cmp_en),
      .background_color (background_color),
      .poly_color       (poly_color),
      .v0_x             (v0_x),
      .v1_x             (v1_x),
      .v2_x             (v2_x),
      .v0_y             (v0_y),
      .v1_y             (v1_y),
      .v2_y             (v2_y),
      .commit_pending   (commit_pending),
      .cmd_err          (cmd_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         sh_c[i] = '0; ac_c[i] = '0;
         for (int v = 0; v < 3; v++) begin
            sh_x[i][v] = '0; sh_y[i][v] = '0;
            ac_x[i][v] = '0; ac_y[i][v] = '0;
         end
      end
      sh_bg = '0; ac_bg = '0; sh_en = '0; ac_en = '0;
   endtask

   task automatic model_swap();
      for (int i = 0; i < 6; i++) begin
         ac_c[i] = sh_c[i];
         for (int v = 0; v < 3; v++) begin
            ac_x[i][v] = sh_x[i][v];
            ac_y[i][v] = sh_y[i][v];
         end
      end
      ac_bg = sh_bg;
      ac_en = sh_en;
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send(input logic [7:0] b);
      int n;
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic load(input logic [2:0] idx, input bit gaps);
      send({3'd1, 2'b00, idx});
      for (int k = 0; k < 13; k++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
         send(pl[k]);
      end
      if (idx < 3'd6) begin
         sh_c[idx] = pl[0][5:0];
         for (int v = 0; v < 3; v++) begin
            sh_x[idx][v] = {pl[2 + 4*v][1:0], pl[1 + 4*v]};
            sh_y[idx][v] = {pl[4 + 4*v][0],   pl[3 + 4*v]};
         end
      end
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic commit_swap();
      send(8'h80);
      chk("commit_pending_set", 64'(commit_pending), 64'd1);
      chk("ready_low_wait", 64'(in_ready), 64'd0);
      repeat (2) @(negedge clk);
      pulse_fs();
      model_swap();
      chk("commit_pending_clr", 64'(commit_pending), 64'd0);
      chk("ready_after_swap", 64'(in_ready), 64'd1);
   endtask

   task automatic check_active(input string tag);
      for (int i = 0; i < 6; i++) begin
         chk({tag, "_color"}, 64'(poly_color[i*6 +: 6]), 64'(ac_c[i]));
         chk({tag, "_v0x"}, 64'(v0_x[i*10 +: 10]), 64'(ac_x[i][0]));
         chk({tag, "_v1x"}, 64'(v1_x[i*10 +: 10]), 64'(ac_x[i][1]));
         chk({tag, "_v2x"}, 64'(v2_x[i*10 +: 10]), 64'(ac_x[i][2]));
         chk({tag, "_v0y"}, 64'(v0_y[i*9 +: 9]), 64'(ac_y[i][0]));
         chk({tag, "_v1y"}, 64'(v1_y[i*9 +: 9]), 64'(ac_y[i][1]));
         chk({tag, "_v2y"}, 64'(v2_y[i*9 +: 9]), 64'(ac_y[i][2]));
      end
      chk({tag, "_bg"}, 64'(background_color), 64'(ac_bg));
      chk({tag, "_en"}, 64'(cmp_en), 64'(ac_en));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_en"}, 64'(cmp_en), 64'd0);
      chk({tag, "_bg"}, 64'(background_color), 64'd0);
      chk({tag, "_color"}, 64'(poly_color), 64'd0);
      chk({tag, "_x"}, 64'(v0_x | v1_x | v2_x), 64'd0);
      chk({tag, "_y"}, 64'(v0_y | v1_y | v2_y), 64'd0);
      chk({tag, "_pend"}, 64'(commit_pending), 64'd0);
      chk({tag, "_err"}, 64'(cmd_err), 64'd0);
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; frame_start = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("rst_hold");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("rst_rel");

      // 1: basic load, enable, commit and swap
      pl = '{8'h2A, 8'd10, 8'd0, 8'd20, 8'd0, 8'd100, 8'd0, 8'd20, 8'd0, 8'd50, 8'd0, 8'd80, 8'd0};
      load(3'd2, 1'b0);
      send(8'h60); send(8'h04); sh_en = 6'h04;
      commit_swap();
      chk("t1_v0x_s2", 64'(v0_x[20 +: 10]), 64'd10);
      chk("t1_v1x_s2", 64'(v1_x[20 +: 10]), 64'd100);
      chk("t1_v2y_s2", 64'(v2_y[18 +: 9]), 64'd80);
      chk("t1_color_s2", 64'(poly_color[12 +: 6]), 64'h2A);
      chk("t1_en", 64'(cmp_en), 64'b000100);
      check_active("t1");

      // 2: shadow load without commit is invisible
      pl = '{8'h11, 8'd1, 8'd1, 8'd2, 8'd1, 8'd3, 8'd0, 8'd4, 8'd0, 8'd5, 8'd0, 8'd6, 8'd0};
      load(3'd0, 1'b0);
      repeat (3) begin
         pulse_fs();
         @(negedge clk);
      end
      chk("t2_v0x_s0", 64'(v0_x[9:0]), 64'd0);
      chk("t2_pend", 64'(commit_pending), 64'd0);
      check_active("t2");

      // 3a: in_ready stays low under held in_valid until swap
      in_data = 8'h80; in_valid = 1'b1;
      @(negedge clk);
      in_data = 8'h00;
      for (int c = 0; c < 3; c++) begin
         chk("t3_ready_low", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0; in_valid = 1'b0;
      model_swap();
      chk("t3_ready_back", 64'(in_ready), 64'd1);
      chk("t3_v0x_s0", 64'(v0_x[9:0]), 64'h101);
      check_active("t3a");

      // 3b: COMMIT accepted together with frame_start waits a frame
      send(8'h40); send(8'h15); sh_bg = 6'h15;
      in_data = 8'h80; in_valid = 1'b1; frame_start = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; frame_start = 1'b0;
      chk("t3_coinc_pend", 64'(commit_pending), 64'd1);
      chk("t3_coinc_ready", 64'(in_ready), 64'd0);
      chk("t3_coinc_bg_old", 64'(background_color), 64'd0);
      @(negedge clk);
      pulse_fs();
      model_swap();
      chk("t3_coinc_bg_new", 64'(background_color), 64'h15);
      chk("t3_coinc_ready2", 64'(in_ready), 64'd1);

      // 4: out-of-range LOAD consumed and dropped, error sticky
      for (int k = 0; k < 13; k++) pl[k] = 8'hFF;
      load(3'd7, 1'b0);
      chk("t4_err", 64'(cmd_err), 64'd1);
      send(8'h40); send(8'h3F); sh_bg = 6'h3F;
      commit_swap();
      chk("t4_bg", 64'(background_color), 64'h3F);
      chk("t4_err_sticky", 64'(cmd_err), 64'd1);
      check_active("t4");

      // 5: reset in the middle of a LOAD payload
      send(8'h21);
      for (int k = 0; k < 5; k++) send(8'hAA);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      check_all_zero("t5_rst");
      rst = 1'b0;
      @(negedge clk);
      send(8'hE0);
      chk("t5_badop_err", 64'(cmd_err), 64'd1);
      chk("t5_badop_ready", 64'(in_ready), 64'd1);
      pl = '{8'hFF, 8'h34, 8'h02, 8'hC8, 8'h01, 8'h07, 8'hFE, 8'h09, 8'hFF, 8'h07, 8'h00, 8'h08, 8'h00};
      load(3'd1, 1'b0);
      send(8'h60); send(8'h02); sh_en = 6'h02;
      commit_swap();
      chk("t5_color_s1", 64'(poly_color[6 +: 6]), 64'h3F);
      chk("t5_v0x_s1", 64'(v0_x[10 +: 10]), 64'h234);
      chk("t5_v0y_s1", 64'(v0_y[9 +: 9]), 64'h1C8);
      chk("t5_v1x_s1", 64'(v1_x[10 +: 10]), 64'h207);
      chk("t5_v1y_s1", 64'(v1_y[9 +: 9]), 64'h109);
      chk("t5_v0x_s2", 64'(v0_x[20 +: 10]), 64'd0);
      check_active("t5");

      // 6: all slots with random payloads and valid gaps
      for (int s = 0; s < 6; s++) begin
         for (int k = 0; k < 13; k++) pl[k] = 8'($urandom);
         load(3'(s), 1'b1);
      end
      send(8'h60); send(8'hFF); sh_en = 6'h3F;
      commit_swap();
      chk("t6_en", 64'(cmp_en), 64'h3F);
      check_active("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
